// File: rtl/hazard_control_unit.sv
// hazard_control_unit: load-use and mult/div stall/flush control for the decode stage
module hazard_control_unit #(
    parameter int MD_LATENCY = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [4:0]  IDRs,
    input  logic [4:0]  IDRt,
    input  logic        IDUsesRt,
    input  logic        IDMulDiv,
    input  logic        IDReadsHiLo,
    input  logic        EXMemRead,
    input  logic [4:0]  EXRt,
    input  logic        EXBranchTaken,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXFlush,
    output logic        MDBusy,
    output logic [31:0] StallCount
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic        lu, mh, stall, issue;
    always_comb begin
        lu = EXMemRead && EXRt != 5'd0 && (EXRt == IDRs || (IDUsesRt && EXRt == IDRt));
        mh = state_q == BUSY && (IDMulDiv || IDReadsHiLo);
        stall = (lu || mh) && !EXBranchTaken;
        issue = IDMulDiv && !stall && !EXBranchTaken && !Rst;
        PCWrite = !Rst && (EXBranchTaken || !stall);
        IFIDWrite = PCWrite;
        IFIDFlush = Rst || EXBranchTaken;
        IDEXFlush = Rst || EXBranchTaken || stall;
        // a branch never aborts BUSY: the issued mult/div is older than the branch
        state_d = state_q == IDLE ? (issue ? BUSY : IDLE) : (cnt_q == 5'd1 ? IDLE : BUSY);
        cnt_d = state_q == IDLE ? (issue ? 5'(MD_LATENCY - 1) : 5'd0) : cnt_q - 5'd1;
        stall_cnt_d = (!PCWrite && stall_cnt_q != '1) ? stall_cnt_q + 32'd1 : stall_cnt_q;
    end
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            cnt_q <= 5'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
    assign MDBusy = state_q == BUSY;
    assign StallCount = stall_cnt_q;
endmodule

// File: doc/hazard_control_unit.md
# hazard_control_unit

Pipeline hazard and stall controller for the five-stage MIPS datapath. It decides each cycle whether the decode/execute pipeline register captures the decoded instruction or a bubble, whether the PC and fetch/decode register advance, and when younger instructions are flushed. It also tracks the multi-cycle multiply/divide unit so that dependent instructions wait in decode. It sits beside the decode stage and drives the write-enable and flush controls of the PC, fetch/decode and decode/execute registers.

## Interface
Parameters:
- MD_LATENCY, 8, cycles a mult/div occupies the unit after issue; legal range 2..31.

Ports:
- Clk  in  1  clock, all state updates on posedge.
- Rst  in  1  synchronous, active-high reset.
- IDRs  in  5  rs field of the instruction in decode.
- IDRt  in  5  rt field of the instruction in decode.
- IDUsesRt  in  1  decode instruction reads rt as a source.
- IDMulDiv  in  1  decode instruction is mult/multu/div/divu.
- IDReadsHiLo  in  1  decode instruction is mfhi/mflo.
- EXMemRead  in  1  execute-stage instruction is a load.
- EXRt  in  5  destination register of the execute-stage load.
- EXBranchTaken  in  1  branch/jump resolved taken in execute this cycle.
- PCWrite  out  1  PC may update.
- IFIDWrite  out  1  fetch/decode register may capture.
- IFIDFlush  out  1  fetch/decode register loads a NOP.
- IDEXFlush  out  1  decode/execute register loads a bubble (all control zero).
- MDBusy  out  1  mult/div unit occupied (state BUSY).
- StallCount  out  32  cycles in which PCWrite was 0 since reset.

## Operation
- Load-use hazard (LU) = EXMemRead & (EXRt != 0) & ((EXRt == IDRs) | (IDUsesRt & (EXRt == IDRt))).
- Mult/div hazard (MH) = (state == BUSY) & (IDMulDiv | IDReadsHiLo).
- Stall = (LU | MH) & ~EXBranchTaken.
- Output priority, evaluated combinationally from state and inputs:
  - Rst = 1: PCWrite = 0, IFIDWrite = 0, IFIDFlush = 1, IDEXFlush = 1.
  - EXBranchTaken: PCWrite = 1, IFIDWrite = 1, IFIDFlush = 1, IDEXFlush = 1. Any hazard is ignored because the decode instruction is squashed.
  - Stall: PCWrite = 0, IFIDWrite = 0, IFIDFlush = 0, IDEXFlush = 1.
  - Otherwise: PCWrite = 1, IFIDWrite = 1, both flushes 0.
- Issue event = IDMulDiv & ~Stall & ~EXBranchTaken & ~Rst. This is the cycle the mult/div enters execute.
- State machine uses a down-counter Cnt with width 5:
  - IDLE: on an issue event, Cnt <= MD_LATENCY-1 and go to BUSY.
  - BUSY: Cnt decrements by 1 each cycle. When Cnt == 1, go to IDLE with Cnt <= 0 on the next edge. No issue can occur in BUSY because MH stalls any mult/div in decode.
  - The busy window is therefore exactly MD_LATENCY-1 cycles after the issue cycle.
  - EXBranchTaken does not abort BUSY, because the issued mult/div is older than the branch.
- StallCount increments on every edge where PCWrite == 0 and Rst == 0. It saturates at 0xFFFFFFFF and does not wrap.
- Register $0 never creates a load-use hazard.

## Timing
- Reset values: state IDLE, Cnt 0, MDBusy 0, StallCount 0. Combinational outputs follow the Rst row above while Rst is held.
- Reset mid-BUSY: on the next edge, state goes to IDLE and Cnt to 0. The first cycle after Rst deasserts behaves as IDLE.
- LU stall lasts exactly 1 cycle. On the next cycle the load has moved to memory, LU drops, and the dependent instruction proceeds.
- Hazard outputs are combinational, with zero-cycle latency from inputs. Only state, Cnt and StallCount are registered.
- MDBusy rises the cycle after the issue event and stays high for MD_LATENCY-1 cycles.
- A stalled mfhi/mflo or mult/div issues in the first cycle MDBusy is 0.
- LU and MH in the same cycle: one stall cycle is generated, and StallCount increments once.

## Test plan
- Load-use: EXMemRead = 1, EXRt = 5, IDRs = 5 -> one cycle with PCWrite = 0, IFIDWrite = 0, IDEXFlush = 1, StallCount 0 -> 1. Repeat with EXRt = 0 -> no stall.
- rt dependency: EXRt = 7, IDRt = 7, IDUsesRt = 0 -> no stall. Same with IDUsesRt = 1 -> stall.
- Branch priority: EXBranchTaken = 1 while LU is true -> PCWrite = 1, IFIDFlush = 1, IDEXFlush = 1, StallCount unchanged.
- Mult/div: issue mult with MD_LATENCY = 8, then mflo in decode -> MDBusy high 7 cycles, 7 stall cycles, mflo issues on the cycle MDBusy falls.
- Back-to-back mult/div: the second mult/div stalls until BUSY ends, then re-enters BUSY the following cycle. A branch flush of a decode mult/div leaves the state IDLE.
- Reset: assert Rst during BUSY with Cnt = 4 -> next cycle MDBusy = 0, StallCount = 0. Force StallCount = 0xFFFFFFFF with a continued stall -> value holds.
